// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_e;

    typedef logic [1:0]      digit_idx_t;
    typedef logic [3:0][3:0] snap_t;

    localparam logic [3:0] AN_OFF = 4'b1111;

    // A digit is hidden only when it and every digit to its left are zero.
    function automatic logic digit_visible(snap_t snap, digit_idx_t idx, logic lz_en);
        logic vis;
        vis = 1'b1;
        if (lz_en) begin
            case (idx)
                2'd3:    vis = (snap[3] != 4'd0);
                2'd2:    vis = |{snap[3], snap[2]};
                2'd1:    vis = |{snap[3], snap[2], snap[1]};
                default: vis = 1'b1;
            endcase
        end
        return vis;
    endfunction

    function automatic logic [3:0] an_onehot(digit_idx_t idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Per-slot cycle counter: flags the last DRIVE cycle and the last cycle of a slot.
module seg_slot_timer #(
    parameter int DIV       = 4000,
    parameter int BLANK_CYC = 400
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    output logic end_drive_o,
    output logic end_slot_o,
    output logic last_next_o
);

    localparam int              CW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   LAST       = CW'(DIV - 1);
    localparam logic [CW-1:0]   DRIVE_LAST = CW'(DIV - BLANK_CYC - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        // NOTE: default assignment first so no path leaves cnt_d unassigned (no latch).
        cnt_d = cnt_q + CW'(1);
        if (clear_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign end_drive_o = (cnt_q == DRIVE_LAST);
    assign end_slot_o  = (cnt_q == LAST);
    // Lets the top register frame_tick so it lands on the frame's final cycle.
    assign last_next_o = (cnt_d == LAST);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed display scanner with dead time, leading-zero
// suppression, alarm blinking and a per-frame digit snapshot.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIV          = 4000,
    parameter int BLANK_CYC    = 400,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] bin0,
    input  logic [3:0] bin1,
    input  logic [3:0] bin2,
    input  logic [3:0] bin3,
    input  logic       lz_en,
    input  logic       blink_en,
    output logic [3:0] AN,
    output logic [3:0] small_bin,
    output logic [1:0] digit_idx,
    output logic       frame_tick
);

    localparam int            BW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BW-1:0] BLAST = BW'(BLINK_FRAMES - 1);

    state_e        state_q, state_d;
    digit_idx_t    idx_q, idx_d;
    snap_t         snap_q, snap_d;
    logic [3:0]    an_q, an_d;
    logic [3:0]    sb_q, sb_d;
    logic          ft_q, ft_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
    logic          visible;

    logic end_drive;
    logic end_slot;
    logic last_next;

    seg_slot_timer #(
        .DIV       (DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_slot_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (state_q == LOAD),
        .end_drive_o (end_drive),
        .end_slot_o  (end_slot),
        .last_next_o (last_next)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        snap_d      = snap_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;

        case (state_q)
            LOAD: begin
                snap_d  = {bin3, bin2, bin1, bin0};
                idx_d   = '0;
                state_d = DRIVE;
            end
            DRIVE, GAP: begin
                // end_slot wins over end_drive so a zero dead time skips GAP.
                if (end_slot) begin
                    if (idx_q == 2'd3) begin
                        idx_d   = '0;
                        state_d = LOAD;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = DRIVE;
                    end
                end else if (end_drive && (state_q == DRIVE)) begin
                    state_d = GAP;
                end
            end
            default: state_d = LOAD;
        endcase

        if (!blink_en) begin
            blink_cnt_d = '0;
            phase_d     = 1'b1;
        end else if (ft_q) begin
            if (blink_cnt_q == BLAST) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end

        // Live lz_en/blink_en gate the very next AN value; the digits come from the snapshot.
        visible = digit_visible(snap_d, idx_d, lz_en) && (!blink_en || phase_q);
        an_d    = ((state_d == DRIVE) && visible) ? an_onehot(idx_d) : AN_OFF;
        sb_d    = (state_d == LOAD) ? sb_q : snap_d[idx_d];
        ft_d    = (state_d != LOAD) && (idx_d == 2'd3) && last_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            idx_q       <= '0;
            snap_q      <= '0;
            an_q        <= AN_OFF;
            sb_q        <= '0;
            ft_q        <= 1'b0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            snap_q      <= snap_d;
            an_q        <= an_d;
            sb_q        <= sb_d;
            ft_q        <= ft_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign AN         = an_q;
    assign small_bin  = sb_q;
    assign digit_idx  = idx_q;
    assign frame_tick = ft_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: one instance with a one-cycle dead time,
// a second with none, both fed identical stimulus so their frames stay aligned.
module tb_seg_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] bin0, bin1, bin2, bin3;
    logic       lz_en;
    logic       blink_en;

    logic [3:0] an_g, sb_g;
    logic [1:0] idx_g;
    logic       ft_g;
    logic [3:0] an_z, sb_z;
    logic [1:0] idx_z;
    logic       ft_z;

    int n_cmp = 0;
    int n_err = 0;

    seg_scan_ctrl #(.DIV(4), .BLANK_CYC(1), .BLINK_FRAMES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bin0       (bin0),
        .bin1       (bin1),
        .bin2       (bin2),
        .bin3       (bin3),
        .lz_en      (lz_en),
        .blink_en   (blink_en),
        .AN         (an_g),
        .small_bin  (sb_g),
        .digit_idx  (idx_g),
        .frame_tick (ft_g)
    );

    seg_scan_ctrl #(.DIV(4), .BLANK_CYC(0), .BLINK_FRAMES(2)) dut_nogap (
        .clk        (clk),
        .rst_n      (rst_n),
        .bin0       (bin0),
        .bin1       (bin1),
        .bin2       (bin2),
        .bin3       (bin3),
        .lz_en      (lz_en),
        .blink_en   (blink_en),
        .AN         (an_z),
        .small_bin  (sb_z),
        .digit_idx  (idx_z),
        .frame_tick (ft_z)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected summary");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " AN"},   8'(an_g),  8'hF);
        chk({tag, " sb"},   8'(sb_g),  8'h0);
        chk({tag, " idx"},  8'(idx_g), 8'h0);
        chk({tag, " ft"},   8'(ft_g),  8'h0);
        chk({tag, " AN0"},  8'(an_z),  8'hF);
        chk({tag, " sb0"},  8'(sb_z),  8'h0);
        chk({tag, " idx0"}, 8'(idx_z), 8'h0);
        chk({tag, " ft0"},  8'(ft_z),  8'h0);
    endtask

    // One 17-cycle frame starting at the cycle after LOAD executes.
    // d_an/d_sb hold the per-slot drive pattern and digit, slot0 in bits [3:0].
    // Cycles before off_until expect all anodes off. After sampling cycle act_k:
    // act 1 loads 9999, act 2 drops blink_en, act 3 asserts reset and returns.
    task automatic check_frame(input string tag, input logic [15:0] d_an,
                               input logic [15:0] d_sb, input int off_until,
                               input int act_k, input int act);
        int         slot, pos;
        logic [3:0] e_an, e_an0, e_sb;
        logic [1:0] e_idx;
        logic       e_ft;
        for (int k = 0; k < 17; k++) begin
            @(posedge clk);
            #1;
            if (k == 16) begin
                e_an  = 4'hF;
                e_an0 = 4'hF;
                e_sb  = d_sb[15:12];
                e_idx = 2'd0;
            end else begin
                slot  = k / 4;
                pos   = k % 4;
                e_sb  = d_sb[slot*4 +: 4];
                e_idx = 2'(slot);
                e_an0 = (k >= off_until) ? d_an[slot*4 +: 4] : 4'hF;
                e_an  = (pos < 3) ? e_an0 : 4'hF;
            end
            e_ft = (k == 15);
            chk($sformatf("%s k%0d AN", tag, k),   8'(an_g),  8'(e_an));
            chk($sformatf("%s k%0d sb", tag, k),   8'(sb_g),  8'(e_sb));
            chk($sformatf("%s k%0d idx", tag, k),  8'(idx_g), 8'(e_idx));
            chk($sformatf("%s k%0d ft", tag, k),   8'(ft_g),  8'(e_ft));
            chk($sformatf("%s k%0d AN0", tag, k),  8'(an_z),  8'(e_an0));
            chk($sformatf("%s k%0d sb0", tag, k),  8'(sb_z),  8'(e_sb));
            chk($sformatf("%s k%0d idx0", tag, k), 8'(idx_z), 8'(e_idx));
            chk($sformatf("%s k%0d ft0", tag, k),  8'(ft_z),  8'(e_ft));
            if (k == act_k) begin
                case (act)
                    1: {bin3, bin2, bin1, bin0} = 16'h9999;
                    2: blink_en = 1'b0;
                    3: begin
                        rst_n = 1'b0;
                        return;
                    end
                    default: ;
                endcase
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        {bin3, bin2, bin1, bin0} = 16'h4321;
        lz_en    = 1'b0;
        blink_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst_n = 1'b1;

        check_frame("f1_plain", 16'h7BDE, 16'h4321, 0, -1, 0);

        {bin3, bin2, bin1, bin0} = 16'h0005;
        lz_en = 1'b1;
        check_frame("f2_lz_5000", 16'hFFFE, 16'h0005, 0, -1, 0);

        {bin3, bin2, bin1, bin0} = 16'h0705;
        check_frame("f3_lz_0705", 16'hFBDE, 16'h0705, 0, -1, 0);

        {bin3, bin2, bin1, bin0} = 16'h4321;
        lz_en = 1'b0;
        check_frame("f4_midchg", 16'h7BDE, 16'h4321, 0, 4, 1);
        check_frame("f5_nines", 16'h7BDE, 16'h9999, 0, -1, 0);

        {bin3, bin2, bin1, bin0} = 16'h2468;
        blink_en = 1'b1;
        check_frame("f6_blk_on", 16'h7BDE, 16'h2468, 0, -1, 0);
        check_frame("f7_blk_on", 16'h7BDE, 16'h2468, 0, -1, 0);
        check_frame("f8_blk_off", 16'h7BDE, 16'h2468, 17, -1, 0);
        check_frame("f9_blk_off", 16'h7BDE, 16'h2468, 17, -1, 0);
        check_frame("f10_blk_on", 16'h7BDE, 16'h2468, 0, -1, 0);
        check_frame("f11_blk_on", 16'h7BDE, 16'h2468, 0, -1, 0);
        check_frame("f12_blk_drop", 16'h7BDE, 16'h2468, 5, 4, 2);
        check_frame("f13_after", 16'h7BDE, 16'h2468, 0, -1, 0);

        check_frame("f14_pre_rst", 16'h7BDE, 16'h2468, 0, 8, 3);
        @(posedge clk);
        #1;
        check_reset("mid_reset");
        rst_n = 1'b1;
        check_frame("f15_resume", 16'h7BDE, 16'h2468, 0, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
